// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(p) add/subtract scheduler.
// The s1 record is the single in-flight operation held between the adder and the correction step.
package gf_pkg;

  localparam int GF_W = 256;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic req_id_t;

  typedef struct packed {
    logic          valid;
    req_id_t       id;
    logic          op;
    logic [GF_W:0] partial;
    logic          carry;
  } s1_t;

endpackage

// File: rtl/gf_addsub_core.sv
// Shared GF(p) add/subtract datapath: first-stage adder into the s1 register, then a
// combinational +/-p correction that the scheduler writes into the requester's output buffer.
module gf_addsub_core
  import gf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            in_valid,
  input  logic            in_id,
  input  logic            in_op,
  input  logic [GF_W-1:0] in_a,
  input  logic [GF_W-1:0] in_b,
  input  logic [GF_W-1:0] p,
  output logic            s1_valid,
  output logic            s1_id,
  output logic [GF_W-1:0] result
);

  s1_t             s1_q;
  s1_t             s1_d;
  logic [GF_W:0]   b_ext;
  logic [GF_W:0]   sum;
  logic [GF_W:0]   p_ext;
  logic [GF_W-1:0] add_red;
  logic            add_ge_p;

  // Subtraction reuses the adder as a + ~b + 1; the carry-out then means a >= b.
  always_comb begin
    b_ext = (in_op == OP_SUB) ? {1'b0, ~in_b} : {1'b0, in_b};
    sum   = {1'b0, in_a} + b_ext + {{GF_W{1'b0}}, (in_op == OP_SUB)};
  end

  always_comb begin
    s1_d = s1_q;
    if (!stall) begin
      s1_d.valid   = in_valid;
      s1_d.id      = req_id_t'(in_id);
      s1_d.op      = in_op;
      s1_d.partial = sum;
      s1_d.carry   = sum[GF_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // A sum of two reduced operands is below 2p, so one conditional subtract suffices.
  always_comb begin
    p_ext    = {1'b0, p};
    add_red  = s1_q.partial[GF_W-1:0] - p;
    add_ge_p = (s1_q.partial >= p_ext);
    if (s1_q.op == OP_SUB) begin
      result = s1_q.carry ? s1_q.partial[GF_W-1:0] : (s1_q.partial[GF_W-1:0] + p);
    end else begin
      result = add_ge_p ? add_red : s1_q.partial[GF_W-1:0];
    end
  end

  assign s1_valid = s1_q.valid;
  assign s1_id    = s1_q.id;

endmodule

// File: rtl/gf_addsub_sched.sv
// Round-robin scheduler sharing one pipelined GF(p) add/sub datapath between two requesters,
// each with its own one-entry response buffer.
module gf_addsub_sched
  import gf_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [GF_W-1:0] p,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_op,
  input  logic [GF_W-1:0] req0_a,
  input  logic [GF_W-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_op,
  input  logic [GF_W-1:0] req1_a,
  input  logic [GF_W-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [GF_W-1:0] rsp0_data,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [GF_W-1:0] rsp1_data,
  output logic            busy
);

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [1:0]      grant;
  logic [1:0]      req_ready;
  logic [1:0]      pop;
  logic            advance;
  logic            stall;
  logic            can_load;
  logic            accept;
  req_id_t         gnt_id;
  logic            in_op;
  logic [GF_W-1:0] in_a;
  logic [GF_W-1:0] in_b;
  req_id_t         ptr_q;
  req_id_t         ptr_d;
  logic [1:0]      out_valid_q;
  logic [1:0]      out_valid_d;
  logic [GF_W-1:0] out_data_q [2];
  logic [GF_W-1:0] out_data_d [2];
  logic            s1_valid;
  logic            s1_id;
  logic [GF_W-1:0] result;

  // The pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    req_valid = {req1_valid, req0_valid};
    rsp_ready = {rsp1_ready, rsp0_ready};
    grant     = req_valid;
    if (&req_valid) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // s1 drains only into a free (or simultaneously popped) buffer of its own requester,
  // so a full buffer blocks both requesters until it is consumed.
  always_comb begin
    pop       = out_valid_q & rsp_ready;
    advance   = s1_valid & (~out_valid_q[s1_id] | pop[s1_id]);
    stall     = s1_valid & ~advance;
    can_load  = rst_n & ~stall;
    req_ready = grant & {2{can_load}};
    accept    = |req_ready;
    gnt_id    = req_id_t'(grant[1]);
    in_op     = gnt_id ? req1_op : req0_op;
    in_a      = gnt_id ? req1_a  : req0_a;
    in_b      = gnt_id ? req1_b  : req0_b;
    ptr_d     = accept ? req_id_t'(~gnt_id) : ptr_q;
  end

  gf_addsub_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .in_valid (accept),
    .in_id    (gnt_id),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .p        (p),
    .s1_valid (s1_valid),
    .s1_id    (s1_id),
    .result   (result)
  );

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      out_valid_d[n] = out_valid_q[n] & ~pop[n];
      out_data_d[n]  = out_data_q[n];
    end
    if (advance) begin
      out_valid_d[s1_id] = 1'b1;
      out_data_d[s1_id]  = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= 1'b0;
      out_valid_q   <= 2'b00;
      out_data_q[0] <= '0;
      out_data_q[1] <= '0;
    end else begin
      ptr_q         <= ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q[0] <= out_data_d[0];
      out_data_q[1] <= out_data_d[1];
    end
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = out_valid_q[0];
  assign rsp1_valid = out_valid_q[1];
  assign rsp0_data  = out_data_q[0];
  assign rsp1_data  = out_data_q[1];
  assign busy       = s1_valid | (|out_valid_q);

endmodule

// File: tb/tb_gf_addsub_sched.sv
// Scoreboard bench for gf_addsub_sched: drivers push expected results from a plain-arithmetic
// reference model, a free-running monitor pops and compares whenever a response is consumed.
module tb_gf_addsub_sched;
  import gf_pkg::*;

  typedef struct packed {
    logic [255:0] data;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] p;
  logic         req0_valid, req0_ready, req0_op;
  logic [255:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_op;
  logic [255:0] req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready;
  logic [255:0] rsp0_data;
  logic         rsp1_valid, rsp1_ready;
  logic [255:0] rsp1_data;
  logic         busy;

  exp_t         exp_q0[$];
  exp_t         exp_q1[$];
  int           grant_q[$];
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  int           rdy_pct[2];
  bit           lat_check = 1'b0;
  bit           hold0 = 1'b0, hold1 = 1'b0;
  logic [255:0] held0, held1;
  logic [255:0] p25519;

  gf_addsub_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p          (p),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_val(input string name, input logic [255:0] got, input logic [255:0] expv);
    checks++;
    if (got === expv) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, got, expv);
  endfunction

  function automatic void check_bit(input string name, input logic got, input logic expv);
    checks++;
    if (got === expv) passes++;
    else $display("[TB] FAIL %s: got %b, required %b", name, got, expv);
  endfunction

  // Reference: plain modular arithmetic on wide integers.
  function automatic logic [255:0] ref_model(input logic op, input logic [255:0] a, input logic [255:0] b,
                                             input logic [255:0] pm);
    logic [256:0] wa, wb, wp, r;
    wa = {1'b0, a};
    wb = {1'b0, b};
    wp = {1'b0, pm};
    if (op == OP_ADD) r = (wa + wb) % wp;
    else r = (wa + wp - wb) % wp;
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand_wide();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [255:0] gen_p();
    logic [255:0] r;
    int k;
    k = int'($urandom_range(2));
    if (k == 0) r = 256'($urandom_range(65535, 3)) | 256'd1;
    else if (k == 1) r = rand_wide() | 256'd1 | (256'd1 << 255);
    else r = (rand_wide() >> $urandom_range(250, 1)) | 256'd1;
    if (r < 256'd3) r = 256'd3;
    return r;
  endfunction

  function automatic logic [255:0] rand_operand(input logic [255:0] pm);
    int k;
    k = int'($urandom_range(9));
    if (k == 0) return '0;
    if (k == 1) return pm - 256'd1;
    return rand_wide() % pm;
  endfunction

  task automatic driveReq(input int n, input logic v, input logic op, input logic [255:0] a, input logic [255:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic applyStimulus(input int n, input logic op, input logic [255:0] a, input logic [255:0] b,
                               input logic [255:0] expv);
    bit   accepted;
    logic rdy;
    exp_t e;
    accepted = 1'b0;
    @(negedge clk);
    driveReq(n, 1'b1, op, a, b);
    for (int w = 0; w < 2000; w++) begin
      #4;
      rdy = (n == 0) ? req0_ready : req1_ready;
      if (rdy) begin
        e.data = expv;
        e.cyc  = cyc;
        if (n == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        grant_q.push_back(n);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      checks++;
      $display("[TB] FAIL req%0d_accept: got no handshake, required one within 2000 cycles", n);
    end
    @(posedge clk);
    #1;
    driveReq(n, 1'b0, op, a, b);
  endtask

  task automatic checkOutput(input int n, input logic [255:0] data);
    exp_t e;
    int   sz;
    sz = (n == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      checks++;
      $display("[TB] FAIL rsp%0d_unexpected: got %0h, required no response", n, data);
      return;
    end
    if (n == 0) e = exp_q0.pop_front();
    else e = exp_q1.pop_front();
    check_val((n == 0) ? "rsp0_data" : "rsp1_data", data, e.data);
    if (lat_check) begin
      checks++;
      if (cyc - e.cyc == 2) passes++;
      else $display("[TB] FAIL rsp%0d_latency: got %0d cycles, required 2", n, cyc - e.cyc);
    end
  endtask

  // Monitor: throttles the response channels and scores every consumed result.
  initial begin
    forever begin
      @(negedge clk);
      rsp0_ready = (int'($urandom_range(99)) < rdy_pct[0]);
      rsp1_ready = (int'($urandom_range(99)) < rdy_pct[1]);
      #4;
      if (hold0 && rsp0_valid) check_val("rsp0_hold", rsp0_data, held0);
      if (hold1 && rsp1_valid) check_val("rsp1_hold", rsp1_data, held1);
      hold0 = rsp0_valid && !rsp0_ready;
      held0 = rsp0_data;
      hold1 = rsp1_valid && !rsp1_ready;
      held1 = rsp1_data;
      if (rsp0_valid && rsp0_ready) checkOutput(0, rsp0_data);
      if (rsp1_valid && rsp1_ready) checkOutput(1, rsp1_data);
    end
  end

  task automatic waitDrain(input string name);
    int i;
    i = 0;
    @(negedge clk);
    #4;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy) && i < 5000) begin
      @(negedge clk);
      #4;
      i++;
    end
    checks++;
    if (i < 5000) passes++;
    else $display("[TB] FAIL %s_drain: got %0d+%0d results pending, required 0", name, exp_q0.size(), exp_q1.size());
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomStream(input int n, input int cnt, input bit gaps);
    logic         op;
    logic [255:0] a, b;
    for (int i = 0; i < cnt; i++) begin
      if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      op = 1'($urandom_range(1));
      a  = rand_operand(p);
      b  = rand_operand(p);
      applyStimulus(n, op, a, b, ref_model(op, a, b, p));
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    p25519 = (256'd1 << 255) - 256'd19;
    p = 256'd23;
    rdy_pct[0] = 100;
    rdy_pct[1] = 100;
    driveReq(0, 1'b1, OP_ADD, 256'd1, 256'd2);
    driveReq(1, 1'b1, OP_ADD, 256'd3, 256'd4);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    repeat (2) @(negedge clk);
    #4;
    check_bit("reset_req0_ready", req0_ready, 1'b0);
    check_bit("reset_req1_ready", req1_ready, 1'b0);
    check_bit("reset_rsp0_valid", rsp0_valid, 1'b0);
    check_bit("reset_rsp1_valid", rsp1_valid, 1'b0);
    check_val("reset_rsp0_data", rsp0_data, 256'd0);
    check_val("reset_rsp1_data", rsp1_data, 256'd0);
    check_bit("reset_busy", busy, 1'b0);
    driveReq(0, 1'b0, OP_ADD, '0, '0);
    driveReq(1, 1'b0, OP_ADD, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] small modulus directed ops");
    lat_check = 1'b1;
    applyStimulus(0, OP_SUB, 256'd5, 256'd9, 256'd19);
    applyStimulus(0, OP_SUB, 256'd9, 256'd5, 256'd4);
    applyStimulus(0, OP_ADD, 256'd20, 256'd7, 256'd4);
    applyStimulus(0, OP_ADD, 256'd3, 256'd4, 256'd7);
    applyStimulus(0, OP_ADD, 256'd22, 256'd1, 256'd0);
    applyStimulus(0, OP_SUB, 256'd22, 256'd22, 256'd0);
    waitDrain("p23");

    $display("[TB] full-width modulus directed ops");
    p = p25519;
    applyStimulus(1, OP_SUB, 256'd0, 256'd1, p25519 - 256'd1);
    applyStimulus(1, OP_ADD, p25519 - 256'd1, p25519 - 256'd1, p25519 - 256'd2);
    applyStimulus(1, OP_SUB, 256'd1, p25519 - 256'd1, 256'd2);
    waitDrain("p25519");
    lat_check = 1'b0;

    $display("[TB] alternating grants");
    resetDut();
    grant_q.delete();
    fork
      randomStream(0, 8, 1'b0);
      randomStream(1, 8, 1'b0);
    join
    waitDrain("alternate");
    check_val("grant_count", 256'(grant_q.size()), 256'd16);
    for (int i = 0; i < 16 && i < grant_q.size(); i++) begin
      checks++;
      if (grant_q[i] == i % 2) passes++;
      else $display("[TB] FAIL grant_order[%0d]: got req%0d, required req%0d", i, grant_q[i], i % 2);
    end

    $display("[TB] output buffer stall");
    p = 256'd23;
    rdy_pct[0] = 0;
    applyStimulus(0, OP_ADD, 256'd1, 256'd2, 256'd3);
    applyStimulus(0, OP_ADD, 256'd3, 256'd4, 256'd7);
    fork
      applyStimulus(0, OP_SUB, 256'd5, 256'd6, 256'd22);
      applyStimulus(1, OP_ADD, 256'd10, 256'd20, 256'd7);
      begin
        repeat (2) begin
          @(negedge clk);
          #4;
          check_bit("stall_req0_ready", req0_ready, 1'b0);
          check_bit("stall_req1_ready", req1_ready, 1'b0);
          check_bit("stall_rsp0_valid", rsp0_valid, 1'b1);
          check_bit("stall_busy", busy, 1'b1);
        end
        rdy_pct[0] = 100;
      end
    join
    waitDrain("stall");

    $display("[TB] reset mid-stream");
    rdy_pct[0] = 0;
    rdy_pct[1] = 0;
    applyStimulus(0, OP_ADD, 256'd1, 256'd1, 256'd2);
    applyStimulus(1, OP_ADD, 256'd2, 256'd2, 256'd4);
    applyStimulus(0, OP_ADD, 256'd3, 256'd3, 256'd6);
    @(negedge clk);
    driveReq(0, 1'b1, OP_ADD, 256'd8, 256'd8);
    #1;
    check_bit("pre_reset_busy", busy, 1'b1);
    check_bit("pre_reset_rsp0_valid", rsp0_valid, 1'b1);
    check_bit("pre_reset_rsp1_valid", rsp1_valid, 1'b1);
    check_bit("pre_reset_req0_ready", req0_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("async_reset_rsp0_valid", rsp0_valid, 1'b0);
    check_bit("async_reset_rsp1_valid", rsp1_valid, 1'b0);
    check_bit("async_reset_req0_ready", req0_ready, 1'b0);
    check_bit("async_reset_busy", busy, 1'b0);
    exp_q0.delete();
    exp_q1.delete();
    driveReq(0, 1'b0, OP_ADD, '0, '0);
    rdy_pct[0] = 100;
    rdy_pct[1] = 100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_check = 1'b1;
    applyStimulus(0, OP_SUB, 256'd2, 256'd3, 256'd22);
    applyStimulus(1, OP_ADD, 256'd11, 256'd12, 256'd0);
    waitDrain("post_reset");
    lat_check = 1'b0;

    $display("[TB] random regression");
    for (int bt = 0; bt < 20; bt++) begin
      p = gen_p();
      rdy_pct[0] = 20 + int'($urandom_range(80));
      rdy_pct[1] = 20 + int'($urandom_range(80));
      fork
        randomStream(0, 250, 1'b1);
        randomStream(1, 250, 1'b1);
      join
      waitDrain("random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gf_addsub_sched.md
# gf_addsub_sched

Scheduler that shares a single pipelined GF(p) add/subtract datapath between two requesters, typically the point-add and point-double sequencers of the elliptic curve processor. It arbitrates round-robin, computes (a ± b) mod p over two register stages and returns each result to the requester that issued it. Each requester has its own valid/ready response channel with a one-entry output buffer.

## Interface
- W, 256, operand/modulus width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- p  in  W  field modulus; static while any operation is in flight
- reqN_valid  in  1  (N = 0, 1) request present
- reqN_ready  out  1  request accepted this cycle when valid & ready
- reqN_op  in  1  0 = ADD, 1 = SUB
- reqN_a, reqN_b  in  W  operands, unsigned, required in [0, p)
- rspN_valid  out  1  result present in requester N's output buffer
- rspN_ready  in  1  requester N consumes result
- rspN_data  out  W  (a ± b) mod p
- busy  out  1  any stage or output buffer holds valid data

## Operation
- Arithmetic:
  - SUB: d = a + ~b + 1, computed W+1 wide. Carry-out 1 (a ≥ b) gives result d[W-1:0]; carry-out 0 gives d + p (mod 2^W).
  - ADD: s = a + b, W+1 wide. Result is s − p if s ≥ p, else s.
  - Operands outside [0, p) give undefined results; no flag is raised.
- Stage 1 register s1 holds {valid, id, op, W+1-bit partial, carry}. Correction (±p compare/select) is computed combinationally from s1 and written into output buffer out[id].
- s1 advances when out[s1.id] is empty or is popped this cycle (rspN_valid & rspN_ready). Otherwise s1 holds: the pipeline stalls and the other requester is head-of-line blocked.
- Issue: s1 can load when s1 is empty or advancing.
  - Arbiter grants one valid requester.
  - reqN_ready = grant[N] & s1_can_load. This depends combinationally on reqN_valid.
- Round-robin: pointer ptr (reset 0) names the preferred requester. After any accepted request, ptr = other requester. With only one requester valid, that requester wins regardless of ptr.
- Requesters hold op/a/b stable while valid & !ready. The block does not require this of itself. Results are returned in issue order per requester.
- Reset (async assert, any time): s1.valid = 0, out[*].valid = 0, ptr = 0, all in-flight results discarded. Outputs: reqN_ready = 0, rspN_valid = 0, rspN_data = 0, busy = 0.

## Timing
- Latency with no stall: handshake in cycle c gives rspN_valid high in cycle c+2.
- Throughput: 1 operation/cycle, alternating between requesters when both stream.
- Output buffer full and not popped: s1 stalls and reqN_ready drops for both requesters in that cycle.
- Pop and refill of the same buffer in one cycle is allowed: rspN_valid stays high and data changes at the edge.
- rspN_data is constant while rspN_valid & !rspN_ready.
- Deassertion of rst_n is synchronous to clk (via external synchronizer). The first handshake is possible in the first cycle after release.

## Structure
- Package gf_pkg holds:
  - GF_W = 256
  - op encoding OP_ADD = 1'b0, OP_SUB = 1'b1
  - typedef for the s1 stage record
  - requester id typedef (1 bit)
- Sub-module gf_addsub_core holds the stage-1 adder (with operand inversion), the s1 register and the correction/select logic, with a stall input. Arbiter, pointer and output buffers stay in gf_addsub_sched.

## Test plan
- p = 23; req0 SUB a=5, b=9 → rsp0_data = 19 at c+2. req0 SUB a=9, b=5 → 4. req0 ADD a=20, b=7 → 4. req0 ADD a=3, b=4 → 7.
- p = 2^255−19; req1 SUB a=0, b=1 → 2^255−20. req1 ADD a=p−1, b=p−1 → p−2. Check full-width carry handling.
- Both requesters valid every cycle from reset, 8 ops each, all ready=1 → grants alternate 0,1,0,1…, first grant to req0, every result delivered to the correct channel in order.
- rsp0_ready=0 with 3 req0 ops issued → buffer full, s1 full, req0_ready and req1_ready low. Then rsp0_ready=1 for 3 cycles → results drain in order, with no loss or duplicates.
- Assert rst_n=0 mid-stream with s1 and both buffers valid → all rsp*_valid, req*_ready and busy at 0 immediately. After release, the next requests complete normally and no stale data appears.
- Random regression: 10k mixed ops against a reference model (x ± y mod p, random p odd, operands < p) with random ready/valid throttling.
